// File: rtl/mult_arbiter_pkg.sv
// rtl/mult_arbiter_pkg.sv - shared types for the multiplier arbiter
package mult_arbiter_pkg;

   // Ids are sized for the largest supported requester count (8), so one
   // tag type serves every NUM_REQ setting.
   localparam int MAX_REQ = 8;
   localparam int ID_W    = $clog2(MAX_REQ);

   typedef logic [ID_W-1:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

   localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/tag_delay_line.sv
// rtl/tag_delay_line.sv - reset-cleared shift register carrying owner tags
module tag_delay_line #(
   parameter int DEPTH = 1,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sr_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
      end
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sharing of one pipelined multiplier
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int DATAWIDTH = 4,
   parameter int LATENCY   = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*DATAWIDTH-1:0]     req_a,
   input  logic [NUM_REQ*DATAWIDTH-1:0]     req_b,
   output logic [NUM_REQ-1:0]               rsp_valid,
   input  logic [NUM_REQ-1:0]               rsp_ready,
   output logic [NUM_REQ*2*DATAWIDTH-1:0]   rsp_z,
   output logic                             mul_i_valid,
   output logic [DATAWIDTH-1:0]             mul_a,
   output logic [DATAWIDTH-1:0]             mul_b,
   input  logic                             mul_o_valid,
   input  logic [2*DATAWIDTH-1:0]           mul_z,
   output logic                             err_unexpected
);

   localparam int PW = 2*DATAWIDTH;

   logic [NUM_REQ-1:0]    busy_q, busy_d;
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [NUM_REQ*PW-1:0] rsp_z_q, rsp_z_d;
   req_id_t               rr_ptr_q, rr_ptr_d;
   logic                  mul_i_valid_q;
   logic [DATAWIDTH-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic                  err_q, err_d;
   logic [NUM_REQ-1:0]    eligible, grant;
   req_id_t               g;
   logic                  accept;
   tag_t                  tag_in, tag_out;

   // Walk from the highest offset down so the last hit is the one nearest rr_ptr.
   always_comb begin
      eligible = req_valid & ~busy_q;
      g        = '0;
      accept   = 1'b0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         int idx;
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (eligible[idx]) begin
            g      = req_id_t'(idx);
            accept = 1'b1;
         end
      end
      grant   = '0;
      mul_a_d = '0;
      mul_b_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = accept && (g == req_id_t'(i));
         if (grant[i]) begin
            mul_a_d = req_a[i*DATAWIDTH +: DATAWIDTH];
            mul_b_d = req_b[i*DATAWIDTH +: DATAWIDTH];
         end
      end
      rr_ptr_d = accept ? req_id_t'((int'(g) + 1) % NUM_REQ) : rr_ptr_q;
   end

   assign tag_in.valid = accept;
   assign tag_in.id    = g;

   tag_delay_line #(.DEPTH(LATENCY+1), .W(TAG_W)) u_tags (
      .clk (clk),
      .rst (rst),
      .d_i (tag_in),
      .q_o (tag_out)
   );

   // A tag that expires without a result still frees its owner.
   always_comb begin
      busy_d      = busy_q;
      rsp_valid_d = rsp_valid_q;
      rsp_z_d     = rsp_z_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rsp_valid_q[i] && rsp_ready[i]) begin
            rsp_valid_d[i] = 1'b0;
            busy_d[i]      = 1'b0;
         end
         if (tag_out.valid && tag_out.id == req_id_t'(i)) begin
            if (mul_o_valid) begin
               rsp_valid_d[i]       = 1'b1;
               rsp_z_d[i*PW +: PW]  = mul_z;
            end else begin
               busy_d[i] = 1'b0;
            end
         end
         if (grant[i]) busy_d[i] = 1'b1;
      end
      err_d = err_q | (mul_o_valid != tag_out.valid);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q        <= '0;
         rsp_valid_q   <= '0;
         rsp_z_q       <= '0;
         rr_ptr_q      <= '0;
         mul_i_valid_q <= 1'b0;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         err_q         <= 1'b0;
      end else begin
         busy_q        <= busy_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_z_q       <= rsp_z_d;
         rr_ptr_q      <= rr_ptr_d;
         mul_i_valid_q <= accept;
         mul_a_q       <= mul_a_d;
         mul_b_q       <= mul_b_d;
         err_q         <= err_d;
      end
   end

   assign req_ready      = grant;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_z          = rsp_z_q;
   assign mul_i_valid    = mul_i_valid_q;
   assign mul_a          = mul_a_q;
   assign mul_b          = mul_b_q;
   assign err_unexpected = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - scoreboard bench over four multiplier latencies
module tb_mult_arbiter;

   localparam int NR = 3;
   localparam int DW = 4;
   localparam int PW = 2*DW;
   localparam int NI = 4;
   localparam int LATS [NI] = '{0, 1, 3, 6};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NR-1:0]    req_valid, rsp_ready;
   logic [NR*DW-1:0] req_a, req_b;
   logic             inject;

   logic [NR-1:0]    rdy [NI];
   logic [NR-1:0]    rv  [NI];
   logic [NR*PW-1:0] rz  [NI];
   logic             m_iv [NI];
   logic [DW-1:0]    m_a [NI];
   logic [DW-1:0]    m_b [NI];
   logic             m_ov [NI];
   logic [PW-1:0]    m_z [NI];
   logic             err [NI];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit err_ok = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar n = 0; n < NI; n++) begin : g_inst
      localparam int L = LATS[n];

      mult_arbiter #(.NUM_REQ(NR), .DATAWIDTH(DW), .LATENCY(L)) dut (
         .clk            (clk),
         .rst            (rst),
         .req_valid      (req_valid),
         .req_ready      (rdy[n]),
         .req_a          (req_a),
         .req_b          (req_b),
         .rsp_valid      (rv[n]),
         .rsp_ready      (rsp_ready),
         .rsp_z          (rz[n]),
         .mul_i_valid    (m_iv[n]),
         .mul_a          (m_a[n]),
         .mul_b          (m_b[n]),
         .mul_o_valid    (m_ov[n]),
         .mul_z          (m_z[n]),
         .err_unexpected (err[n])
      );

      // Behavioural multiplier with L register stages; inject forces o_valid.
      if (L == 0) begin : g_comb
         assign m_ov[n] = m_iv[n] | inject;
         assign m_z[n]  = PW'(m_a[n]) * PW'(m_b[n]);
      end else begin : g_pipe
         logic [L-1:0]  v_sh;
         logic [PW-1:0] z_sh [L];
         always @(posedge clk or posedge rst) begin
            if (rst) begin
               v_sh <= '0;
               for (int k = 0; k < L; k++) z_sh[k] <= '0;
            end else begin
               v_sh[0] <= m_iv[n];
               z_sh[0] <= PW'(m_a[n]) * PW'(m_b[n]);
               for (int k = 1; k < L; k++) begin
                  v_sh[k] <= v_sh[k-1];
                  z_sh[k] <= z_sh[k-1];
               end
            end
         end
         assign m_ov[n] = v_sh[L-1] | inject;
         assign m_z[n]  = z_sh[L-1];
      end
   end

   // Reference model: busy set, round-robin pointer, expected responses.
   bit [NR-1:0] mbusy [NI];
   int          mptr  [NI];
   int          mdue  [NI][NR];
   int unsigned q_z   [NI][NR][$];
   int          q_due [NI][NR][$];

   always @(negedge clk) begin
      int g;
      int idx;
      logic [NR-1:0] exp_rdy;
      for (int n = 0; n < NI; n++) begin
         if (rst) begin
            mbusy[n] = '0;
            mptr[n]  = 0;
            for (int i = 0; i < NR; i++) begin
               q_z[n][i].delete();
               q_due[n][i].delete();
               mdue[n][i] = 0;
            end
         end else begin
            g = -1;
            for (int k = 0; k < NR; k++) begin
               idx = (mptr[n] + k) % NR;
               if (g < 0 && req_valid[idx] && !mbusy[n][idx]) g = idx;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            total++;
            if (rdy[n] !== exp_rdy) begin
               bad++;
               $display("FAIL grant lat=%0d cyc=%0d: got %b want %b", LATS[n], cyc, rdy[n], exp_rdy);
            end
            for (int i = 0; i < NR; i++)
               if (mbusy[n][i] && mdue[n][i] <= cyc && rsp_ready[i]) mbusy[n][i] = 1'b0;
            if (g >= 0) begin
               mbusy[n][g] = 1'b1;
               mptr[n]     = (g + 1) % NR;
               mdue[n][g]  = cyc + 2 + LATS[n];
               q_z[n][g].push_back(int'(req_a[g*DW +: DW]) * int'(req_b[g*DW +: DW]));
               q_due[n][g].push_back(cyc + 2 + LATS[n]);
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever a new response is presented.
   bit [NR-1:0] shown [NI];

   always @(negedge clk) begin
      int unsigned zexp;
      int          dexp;
      for (int n = 0; n < NI; n++) begin
         if (rst) begin
            shown[n] = '0;
         end else begin
            for (int i = 0; i < NR; i++) begin
               if (rv[n][i] && !shown[n][i]) begin
                  total++;
                  if (q_z[n][i].size() == 0) begin
                     bad++;
                     $display("FAIL unexpected_rsp lat=%0d req=%0d cyc=%0d: got z=%0d want none", LATS[n], i, cyc, rz[n][i*PW +: PW]);
                  end else begin
                     zexp = q_z[n][i].pop_front();
                     dexp = q_due[n][i].pop_front();
                     if (rz[n][i*PW +: PW] !== zexp[PW-1:0] || cyc != dexp) begin
                        bad++;
                        $display("FAIL rsp lat=%0d req=%0d: got z=%0d at %0d want z=%0d at %0d", LATS[n], i, rz[n][i*PW +: PW], cyc, zexp, dexp);
                     end
                  end
                  shown[n][i] = 1'b1;
               end else if (shown[n][i] && !rv[n][i]) begin
                  total++;
                  bad++;
                  $display("FAIL rsp_dropped lat=%0d req=%0d cyc=%0d: got 0 want 1", LATS[n], i, cyc);
                  shown[n][i] = 1'b0;
               end
               if (q_due[n][i].size() > 0 && q_due[n][i][0] < cyc) begin
                  total++;
                  bad++;
                  $display("FAIL late_rsp lat=%0d req=%0d cyc=%0d: got none want rsp at %0d", LATS[n], i, cyc, q_due[n][i][0]);
                  void'(q_z[n][i].pop_front());
                  void'(q_due[n][i].pop_front());
               end
               if (rv[n][i] && rsp_ready[i]) shown[n][i] = 1'b0;
            end
            if (!err_ok) begin
               total++;
               if (err[n] !== 1'b0) begin
                  bad++;
                  $display("FAIL err_quiet lat=%0d cyc=%0d: got %b want 0", LATS[n], cyc, err[n]);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input int n, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s lat=%0d: got %0h want %0h", nm, LATS[n], got, want);
      end
   endtask

   task automatic chk_reset_state();
      for (int n = 0; n < NI; n++) begin
         chk("rst_req_ready", n, 32'(rdy[n]), 0);
         chk("rst_rsp_valid", n, 32'(rv[n]), 0);
         chk("rst_rsp_z", n, 32'(rz[n]), 0);
         chk("rst_mul_i_valid", n, 32'(m_iv[n]), 0);
         chk("rst_mul_a", n, 32'(m_a[n]), 0);
         chk("rst_mul_b", n, 32'(m_b[n]), 0);
         chk("rst_err", n, 32'(err[n]), 0);
      end
   endtask

   task automatic chk_drained(input string nm);
      for (int n = 0; n < NI; n++)
         for (int i = 0; i < NR; i++)
            chk(nm, n, q_z[n][i].size(), 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      req_valid = '0;
      rsp_ready = '1;
      req_a     = '0;
      req_b     = '0;
      inject    = 1'b0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_state();
      step();
      rst = 1'b0;

      // Single request: requester 1, 9 x 7.
      step();
      req_a[1*DW +: DW] = 4'd9;
      req_b[1*DW +: DW] = 4'd7;
      req_valid = 3'b010;
      step();
      req_valid = '0;
      repeat (12) step();

      // Contention: everyone valid with 15 x 15.
      req_a = {NR{4'd15}};
      req_b = {NR{4'd15}};
      req_valid = '1;
      repeat (40) step();

      // Backpressure on requester 0 while the others keep going.
      rsp_ready = 3'b110;
      for (int c = 0; c < 10; c++) begin
         req_a = NR*DW'($urandom);
         req_b = NR*DW'($urandom);
         step();
      end
      rsp_ready = '1;

      // Random traffic.
      for (int c = 0; c < 300; c++) begin
         req_valid = NR'($urandom);
         req_a     = NR*DW'($urandom);
         req_b     = NR*DW'($urandom);
         rsp_ready = NR'($urandom_range(0, 7) | $urandom_range(0, 7));
         step();
      end

      req_valid = '0;
      rsp_ready = '1;
      repeat (20) step();
      chk_drained("drained");

      // Error injection: o_valid with nothing in flight.
      err_ok = 1'b1;
      inject = 1'b1;
      step();
      inject = 1'b0;
      @(negedge clk);
      for (int n = 0; n < NI; n++) begin
         chk("err_set", n, 32'(err[n]), 1);
         chk("err_no_rsp", n, 32'(rv[n]), 0);
      end
      repeat (5) @(negedge clk);
      for (int n = 0; n < NI; n++) chk("err_sticky", n, 32'(err[n]), 1);

      step();
      rst = 1'b1;
      #1;
      for (int n = 0; n < NI; n++) chk("err_cleared", n, 32'(err[n]), 0);
      step();
      rst = 1'b0;
      err_ok = 1'b0;

      // Reset one cycle after accepting 3 x 5 on requester 0.
      step();
      req_a[0 +: DW] = 4'd3;
      req_b[0 +: DW] = 4'd5;
      req_valid = 3'b001;
      step();
      req_valid = '0;
      step();
      rst = 1'b1;
      #1;
      chk_reset_state();
      step();
      rst = 1'b0;
      repeat (15) step();
      chk_drained("post_reset_quiet");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
